// File: rtl/mmio_gpio_pkg.sv
// rtl/mmio_gpio_pkg.sv - shared constants for the mmio_gpio peripheral
package mmio_gpio_pkg;

  localparam int PORT_W    = 8;
  localparam int MAX_PORTS = 4;

  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IN      = 3'd2;
  localparam logic [2:0] REG_IEN     = 3'd3;
  localparam logic [2:0] REG_EDGE    = 3'd4;
  localparam logic [2:0] REG_FLAGS   = 3'd5;
  localparam logic [2:0] REG_OUT_SET = 3'd6;
  localparam logic [2:0] REG_OUT_CLR = 3'd7;

endpackage

// File: rtl/gpio_port_edge.sv
// rtl/gpio_port_edge.sv - per-port pin synchroniser and edge event detector
module gpio_port_edge
  import mmio_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              hwclk,
  input  logic              reset_n,
  input  logic [PORT_W-1:0] pins,
  input  logic [PORT_W-1:0] dir,
  input  logic [PORT_W-1:0] edge_sel,
  input  logic              arm,
  output logic [PORT_W-1:0] sync_val,
  output logic [PORT_W-1:0] events
);

  logic [PORT_W-1:0] sync_q [SYNC_STAGES];
  logic [PORT_W-1:0] prev_q;
  logic [PORT_W-1:0] rise;
  logic [PORT_W-1:0] fall;

  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign rise     = sync_val & ~prev_q;
  assign fall     = ~sync_val & prev_q;

  // Output-direction bits never flag, and nothing flags until the chain has settled
  assign events = arm ? (~dir & ((edge_sel & rise) | (~edge_sel & fall))) : '0;

endmodule

// File: rtl/mmio_gpio.sv
// rtl/mmio_gpio.sv - memory-mapped GPIO: register file, read mux and IRQ reduction
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     hwclk,
  input  logic                     reset_n,
  input  logic                     cs,
  input  logic [4:0]               addr,
  input  logic                     rw,
  input  logic [7:0]               idata,
  output logic [7:0]               odata,
  output logic                     irq_n,
  input  logic [PORT_W*NPORTS-1:0] gpio_in,
  output logic [PORT_W*NPORTS-1:0] gpio_out,
  output logic [PORT_W*NPORTS-1:0] gpio_oe
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [NPORTS-1:0][PORT_W-1:0] out_all, dir_all, in_all, ien_all, edge_all, flags_all;
  logic [ARM_W-1:0] arm_cnt;
  logic             arm;
  logic             wr_en;
  logic [7:0]       rdata;

  assign wr_en = cs && !rw;
  assign arm   = (arm_cnt == ARM_W'(ARM_CYCLES));

  always_ff @(posedge hwclk) begin
    if (!reset_n) arm_cnt <= '0;
    else if (!arm) arm_cnt <= arm_cnt + 1'b1;
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [PORT_W-1:0] out_q, dir_q, ien_q, edge_q, flags_q;
    logic [PORT_W-1:0] events;
    logic [PORT_W-1:0] clr;
    logic              hit;

    assign hit = wr_en && (addr[4:3] == 2'(p));
    assign clr = (hit && addr[2:0] == REG_FLAGS) ? idata : '0;

    gpio_port_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
      .hwclk    (hwclk),
      .reset_n  (reset_n),
      .pins     (gpio_in[p*PORT_W +: PORT_W]),
      .dir      (dir_q),
      .edge_sel (edge_q),
      .arm      (arm),
      .sync_val (in_all[p]),
      .events   (events)
    );

    always_ff @(posedge hwclk) begin
      if (!reset_n) begin
        out_q   <= '0;
        dir_q   <= '0;
        ien_q   <= '0;
        edge_q  <= '0;
        flags_q <= '0;
      end else begin
        if (hit) begin
          case (addr[2:0])
            REG_OUT:     out_q  <= idata;
            REG_DIR:     dir_q  <= idata;
            REG_IEN:     ien_q  <= idata;
            REG_EDGE:    edge_q <= idata;
            REG_OUT_SET: out_q  <= out_q | idata;
            REG_OUT_CLR: out_q  <= out_q & ~idata;
            default:     ;
          endcase
        end
        // A new event in the same cycle as a W1C keeps the flag set
        flags_q <= (flags_q & ~clr) | events;
      end
    end

    assign out_all[p]   = out_q;
    assign dir_all[p]   = dir_q;
    assign ien_all[p]   = ien_q;
    assign edge_all[p]  = edge_q;
    assign flags_all[p] = flags_q;
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (addr[4:3] == 2'(p)) begin
        case (addr[2:0])
          REG_OUT:   rdata = out_all[p];
          REG_DIR:   rdata = dir_all[p];
          REG_IN:    rdata = in_all[p];
          REG_IEN:   rdata = ien_all[p];
          REG_EDGE:  rdata = edge_all[p];
          REG_FLAGS: rdata = flags_all[p];
          default:   rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      odata <= '0;
      irq_n <= 1'b1;
    end else begin
      odata <= (cs && rw) ? rdata : '0;
      irq_n <= ~|(flags_all & ien_all);
    end
  end

  assign gpio_out = out_all;
  assign gpio_oe  = dir_all;

endmodule
